// File: rtl/reg_serialize16_tx.sv
// -----------------------------------------------------------------------------
// reg_serialize16_tx
// Parallel-to-serial transmitter feeding an indexed bit collector. A word is
// captured on LOAD and sent MSB first, one bit per clock. Each bit carries a
// write strobe (ena_out_o) and its index (sel_out_o). Index k carries
// DIN[WIDTH-1-k], so the far end can rebuild the word directly.
//
// Optional feature (macro SERTX_PARITY_EN): adds a PARITY beat after the last
// data bit. During that beat dout_o is the XOR of the latched word and
// par_val_o is 1. Without the macro the PARITY state is not built and
// par_val_o is tied to 0. The port list is the same in both builds.
//
// Handshake: ready_o=1 only in IDLE. A LOAD is taken on a rising edge where
// load_i=1, abort_i=0 and ready_o=1. LOAD in any other state is dropped and
// not queued. abort_i wins over load_i.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   load_i       transmit request (accepted only when ready_o=1)
//   abort_i      synchronous frame cancel
//   din_i        parallel word, sampled on the accepting edge only
//   ready_o      1 while IDLE (combinational from state)
//   busy_o       registered, 1 from accept until return to IDLE
//   ena_out_o    registered bit strobe
//   sel_out_o    registered bit index 0..WIDTH-1
//   dout_o       registered serial data bit
//   par_val_o    registered parity-beat marker
//   done_o       registered one-cycle pulse on normal frame completion
//   state_dbg_o  current FSM state, for debug visibility
// -----------------------------------------------------------------------------
module reg_serialize16_tx #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             ena_out_o,
  output logic [IDX_W-1:0] sel_out_o,
  output logic             dout_o,
  output logic             par_val_o,
  output logic             done_o,
  output logic [1:0]       state_dbg_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SERTX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_FIN    = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  // Holds the bits still to be sent; the next bit to send is always the MSB.
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             busy_q, busy_d;
  logic             ena_q, ena_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
`ifdef SERTX_PARITY_EN
  // Parity is computed from the full word at accept time, because the shift
  // register no longer holds the whole word once shifting starts.
  logic             par_q, par_d;
  logic             pv_q, pv_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    ena_d   = 1'b0;
    sel_d   = '0;
    dout_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERTX_PARITY_EN
    par_d   = par_q;
    pv_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_i && !abort_i) begin
          // The first bit leaves on the accepting edge itself.
          state_d = S_SHIFT;
          shreg_d = {din_i[WIDTH-2:0], 1'b0};
          busy_d  = 1'b1;
          ena_d   = 1'b1;
          dout_d  = din_i[WIDTH-1];
`ifdef SERTX_PARITY_EN
          par_d   = ^din_i;
`endif
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
          shreg_d = '0;
          busy_d  = 1'b0;
`ifdef SERTX_PARITY_EN
          par_d   = 1'b0;
`endif
        end else if (sel_q == LAST_IDX) begin
          shreg_d = '0;
`ifdef SERTX_PARITY_EN
          state_d = S_PARITY;
          pv_d    = 1'b1;
          dout_d  = par_q;
`else
          state_d = S_FIN;
          done_d  = 1'b1;
`endif
        end else begin
          ena_d   = 1'b1;
          sel_d   = sel_q + 1'b1;
          dout_d  = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
      end
`ifdef SERTX_PARITY_EN
      S_PARITY: begin
        par_d = 1'b0;
        if (abort_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end
`endif
      S_FIN: begin
        // The FIN cycle is already the final cycle, so ABORT and normal exit
        // both go straight back to IDLE.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      ena_q   <= 1'b0;
      sel_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      ena_q   <= ena_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

`ifdef SERTX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
      pv_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pv_q  <= pv_d;
    end
  end
  assign par_val_o = pv_q;
`else
  assign par_val_o = 1'b0;
`endif

  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = busy_q;
  assign ena_out_o   = ena_q;
  assign sel_out_o   = sel_q;
  assign dout_o      = dout_q;
  assign done_o      = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_reg_serialize16_tx.sv
// -----------------------------------------------------------------------------
// tb_reg_serialize16_tx
// Scoreboard bench for reg_serialize16_tx. The drivers push the expected bit
// beats, parity beats and rebuilt words when they issue a LOAD. A monitor on
// the falling edge pops and compares whenever the DUT strobes. Directed checks
// cover reset, timing, abort and LOAD ignore. Define SERTX_PARITY_EN for both
// the bench and the RTL to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_reg_serialize16_tx;

  localparam int W = 16;

  logic        clk;
  logic        rst;
  logic        load_i;
  logic        abort_i;
  logic [15:0] din_i;
  logic        ready_o;
  logic        busy_o;
  logic        ena_out_o;
  logic [3:0]  sel_out_o;
  logic        dout_o;
  logic        par_val_o;
  logic        done_o;
  logic [1:0]  state_dbg_o;

  reg_serialize16_tx #(.WIDTH(16), .IDX_W(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load_i),
    .abort_i    (abort_i),
    .din_i      (din_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .ena_out_o  (ena_out_o),
    .sel_out_o  (sel_out_o),
    .dout_o     (dout_o),
    .par_val_o  (par_val_o),
    .done_o     (done_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [4:0]  exp_q[$];       // {sel, dout} per data beat
  logic [15:0] exp_done_q[$];  // word the collector must rebuild
  logic        exp_par_q[$];   // expected parity bit per parity beat
  logic [15:0] col;            // model collector at the far end
  int checks;
  int failures;
  int done_cnt;
  int exp_done_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ena_out_o) begin
        if (exp_q.size() == 0) chk("beat_unexpected", {27'd0, sel_out_o, dout_o}, 32'h1f_ffff);
        else chk("beat", {27'd0, sel_out_o, dout_o}, {27'd0, exp_q.pop_front()});
        col[W-1-int'(sel_out_o)] = dout_o;
      end
      if (par_val_o) begin
        if (exp_par_q.size() == 0) chk("parity_unexpected", 32'd1, 32'd0);
        else chk("parity_bit", {31'd0, dout_o}, {31'd0, exp_par_q.pop_front()});
      end
      if (done_o) begin
        done_cnt++;
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("collector_word", {16'd0, col}, {16'd0, exp_done_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues a one-cycle LOAD from an IDLE position; returns at accept edge + 2.
  task automatic send(input logic [15:0] w);
    for (int k = 0; k < W; k++) exp_q.push_back({4'(k), w[W-1-k]});
    exp_done_q.push_back(w);
`ifdef SERTX_PARITY_EN
    exp_par_q.push_back(^w);
`endif
    exp_done_total++;
    load_i = 1'b1;
    din_i  = w;
    tick();
    load_i = 1'b0;
    din_i  = 16'h0;
    chk("accept_busy", {31'd0, busy_o}, 32'd1);
    chk("accept_ena", {31'd0, ena_out_o}, 32'd1);
    chk("accept_sel", {28'd0, sel_out_o}, 32'd0);
  endtask

  task automatic wait_sel(input logic [3:0] k);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ena_out_o && sel_out_o == k) found = 1'b1;
      else tick();
    end
    if (!found) chk("wait_sel_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ready_o) found = 1'b1;
      else tick();
    end
    if (!found) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0; done_cnt = 0; exp_done_total = 0;
    col = '0;
    rst = 1'b1; load_i = 1'b0; abort_i = 1'b0; din_i = 16'h0;
    #12;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_outputs", {26'd0, busy_o, ena_out_o, dout_o, par_val_o, done_o, |sel_out_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Test 2: A5C3 frame with hand-timed FIN/IDLE.
    send(16'hA5C3);
    for (int i = 0; i < 15; i++) tick();
    chk("t2_last_sel", {28'd0, sel_out_o}, 32'd15);
    chk("t2_last_bit", {31'd0, dout_o}, 32'd1);
    tick();
`ifdef SERTX_PARITY_EN
    chk("t2_par_val", {31'd0, par_val_o}, 32'd1);
    tick();
`endif
    chk("t2_fin_done", {31'd0, done_o}, 32'd1);
    chk("t2_fin_busy_ready", {30'd0, busy_o, ready_o}, 32'd2);
    chk("t2_fin_ena_sel", {27'd0, ena_out_o, sel_out_o}, 32'd0);
    tick();
    chk("t2_idle_done", {31'd0, done_o}, 32'd0);
    chk("t2_idle_busy_ready", {30'd0, busy_o, ready_o}, 32'd1);
    tick();

    // Test 3: DIN change plus a second LOAD mid-frame are ignored.
    send(16'hA5C3);
    wait_sel(4'd5);
    din_i = 16'hFFFF; load_i = 1'b1;
    tick();
    load_i = 1'b0; din_i = 16'h0;
    chk("t3_busy", {31'd0, busy_o}, 32'd1);
    chk("t3_sel", {28'd0, sel_out_o}, 32'd6);
    wait_idle();
    for (int i = 0; i < 20; i++) tick();
    chk("t3_one_done", done_cnt, exp_done_total);

    // Test 4: ABORT at SEL=9, then a clean frame of 0001.
    send(16'h1234);
    wait_sel(4'd9);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t4_ena", {31'd0, ena_out_o}, 32'd0);
    chk("t4_busy", {31'd0, busy_o}, 32'd0);
    chk("t4_ready", {31'd0, ready_o}, 32'd1);
    chk("t4_done", {31'd0, done_o}, 32'd0);
    exp_q.delete(); exp_done_q.delete(); exp_par_q.delete();
    exp_done_total--;
    tick();
    send(16'h0001);
    wait_idle();
    tick();
    chk("t4_done_count", done_cnt, exp_done_total);

    // Test 5: LOAD with ABORT in IDLE is not accepted.
    load_i = 1'b1; abort_i = 1'b1; din_i = 16'hBEEF;
    tick();
    load_i = 1'b0; abort_i = 1'b0;
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_ena", {31'd0, ena_out_o}, 32'd0);
    chk("t5_ready", {31'd0, ready_o}, 32'd1);
    for (int i = 0; i < 20; i++) tick();

`ifdef SERTX_PARITY_EN
    // Test 6: parity beat for 0007 (odd count -> 1) and 0003 (even -> 0).
    send(16'h0007);
    wait_sel(4'd15);
    tick();
    chk("t6_pv", {29'd0, par_val_o, dout_o, ena_out_o}, 32'b110);
    chk("t6_sel", {28'd0, sel_out_o}, 32'd0);
    wait_idle();
    tick();
    send(16'h0003);
    wait_sel(4'd15);
    tick();
    chk("t6_pv0", {29'd0, par_val_o, dout_o, ena_out_o}, 32'b100);
    wait_idle();
    tick();
`endif

    // Test 1: RST mid-frame at SEL=7; no DONE afterwards.
    send(16'hA5C3);
    wait_sel(4'd7);
    #5;  // past the monitor's sample of beat 7
    rst = 1'b1;
    #1;
    chk("t1_outputs", {26'd0, busy_o, ena_out_o, dout_o, par_val_o, done_o, |sel_out_o}, 32'd0);
    chk("t1_ready", {31'd0, ready_o}, 32'd1);
    exp_q.delete(); exp_done_q.delete(); exp_par_q.delete();
    exp_done_total--;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("t1_no_done", done_cnt, exp_done_total);
    chk("t1_idle", {30'd0, busy_o, ready_o}, 32'd1);

    chk("final_beats_left", exp_q.size(), 32'd0);
    chk("final_done_left", exp_done_q.size(), 32'd0);
    chk("final_done_count", done_cnt, exp_done_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
